// File: rtl/sw_debounce_pkg.sv
// Shared types and defaults for the switch debouncer slice.
package sw_debounce_pkg;

  typedef enum logic {
    DEB_IDLE,
    DEB_CHECK
  } deb_state_t;

  // 10 ms at 50 MHz
  localparam int unsigned DEFAULT_STABLE_CYCLES = 500000;

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch bit: two-flop synchronizer, IDLE/CHECK FSM with stability counter,
// registered clean level and one-cycle change pulse.
module debounce_channel
  import sw_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic changed
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_s;
  deb_state_t       state;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_s    <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DEB_IDLE;
      count   <= '0;
      clean   <= 1'b0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      unique case (state)
        DEB_IDLE: begin
          if (sync_s != clean) begin
            state <= DEB_CHECK;
            count <= CNT_W'(1);
          end else begin
            count <= '0;
          end
        end
        DEB_CHECK: begin
          if (sync_s == clean) begin
            // Bounced back before the level proved stable
            state <= DEB_IDLE;
            count <= '0;
          end else if (count == CntLast) begin
            clean   <= sync_s;
            changed <= 1'b1;
            state   <= DEB_IDLE;
            count   <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= DEB_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sw_debouncer.sv
// Debounces WIDTH switch channels for the downstream adder and flags when the
// startup settle window has elapsed.
module sw_debouncer
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = 3,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic [WIDTH-1:0] SW_RAW,
  output logic [WIDTH-1:0] SW_CLEAN,
  output logic [WIDTH-1:0] SW_CHANGED,
  output logic             SW_VALID
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] StartupLast = CNT_W'(STABLE_CYCLES);

  if (STABLE_CYCLES < 2) begin : g_param_check
    $error("sw_debouncer: STABLE_CYCLES must be at least 2");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_chan (
      .clk     (CLOCK_50),
      .rst     (RESET),
      .raw     (SW_RAW[i]),
      .clean   (SW_CLEAN[i]),
      .changed (SW_CHANGED[i])
    );
  end

  logic [CNT_W-1:0] startup_cnt;

  // Saturates at STABLE_CYCLES; the valid flag is set on the edge after it saturates
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      startup_cnt <= '0;
      SW_VALID    <= 1'b0;
    end else if (startup_cnt == StartupLast) begin
      SW_VALID <= 1'b1;
    end else begin
      startup_cnt <= startup_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with STABLE_CYCLES=4 and a 10 ns clock.
module tb_sw_debouncer;

  localparam int unsigned WIDTH  = 3;
  localparam int unsigned STABLE = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_changed;
  logic             sw_valid;

  int checks;
  int errors;

  sw_debouncer #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .SW_RAW     (sw_raw),
    .SW_CLEAN   (sw_clean),
    .SW_CHANGED (sw_changed),
    .SW_VALID   (sw_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int pop3(input logic [2:0] v);
    int c;
    c = 0;
    for (int b = 0; b < 3; b++) if (v[b]) c++;
    return c;
  endfunction

  task automatic test_reset;
    rst    = 1'b1;
    sw_raw = 3'b000;
    tick(3);
    checks++;
    if ({sw_clean, sw_changed, sw_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got clean=%b chg=%b valid=%b want all 0",
               sw_clean, sw_changed, sw_valid);
    end
    rst = 1'b0;
    tick(4);
    checks++;
    if (sw_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_early: got %b want 0 after edge 4", sw_valid);
    end
    tick(1);
    checks++;
    if (sw_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_rise: got %b want 1 after edge 5", sw_valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checks++;
      if (sw_clean !== 3'b000 || sw_changed !== 3'b000 || sw_valid !== 1'b1) begin
        errors++;
        $display("FAIL idle_hold[%0d]: got clean=%b chg=%b valid=%b want 000 000 1",
                 i, sw_clean, sw_changed, sw_valid);
      end
    end
  endtask

  task automatic test_change;
    sw_raw = 3'b101;
    tick(5);
    checks++;
    if (sw_clean !== 3'b000 || sw_changed !== 3'b000) begin
      errors++;
      $display("FAIL change_early: got clean=%b chg=%b want 000 000", sw_clean, sw_changed);
    end
    tick(1);
    checks++;
    if (sw_clean !== 3'b101 || sw_changed !== 3'b101) begin
      errors++;
      $display("FAIL change_accept: got clean=%b chg=%b want 101 101", sw_clean, sw_changed);
    end
    tick(1);
    checks++;
    if (sw_clean !== 3'b101 || sw_changed !== 3'b000) begin
      errors++;
      $display("FAIL change_pulse_end: got clean=%b chg=%b want 101 000", sw_clean, sw_changed);
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 10; i++) begin
      sw_raw[1] = (i % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        tick(1);
        checks++;
        if (sw_clean !== 3'b101 || sw_changed !== 3'b000) begin
          errors++;
          $display("FAIL bounce_reject[%0d.%0d]: got clean=%b chg=%b want 101 000",
                   i, k, sw_clean, sw_changed);
        end
      end
    end
    sw_raw[1] = 1'b1;
    tick(5);
    checks++;
    if (sw_clean !== 3'b101) begin
      errors++;
      $display("FAIL bounce_hold_early: got clean=%b want 101", sw_clean);
    end
    tick(1);
    checks++;
    if (sw_clean !== 3'b111 || sw_changed !== 3'b010) begin
      errors++;
      $display("FAIL bounce_hold_accept: got clean=%b chg=%b want 111 010",
               sw_clean, sw_changed);
    end
  endtask

  task automatic test_reset_mid_check;
    // Start from a known clean=000 state
    rst    = 1'b1;
    sw_raw = 3'b000;
    tick(2);
    rst = 1'b0;
    tick(8);
    sw_raw = 3'b111;
    tick(3);
    checks++;
    if (sw_clean !== 3'b000 || sw_changed !== 3'b000) begin
      errors++;
      $display("FAIL midcheck_pending: got clean=%b chg=%b want 000 000", sw_clean, sw_changed);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({sw_clean, sw_changed, sw_valid} !== 7'b0) begin
      errors++;
      $display("FAIL midcheck_async_clear: got clean=%b chg=%b valid=%b want all 0",
               sw_clean, sw_changed, sw_valid);
    end
    tick(1);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      checks++;
      if (sw_clean !== 3'b000 || sw_changed !== 3'b000) begin
        errors++;
        $display("FAIL midcheck_no_pulse[%0d]: got clean=%b chg=%b want 000 000",
                 i, sw_clean, sw_changed);
      end
    end
    tick(1);
    checks++;
    if (sw_clean !== 3'b111 || sw_changed !== 3'b111) begin
      errors++;
      $display("FAIL midcheck_rearm: got clean=%b chg=%b want 111 111", sw_clean, sw_changed);
    end
  endtask

  task automatic test_sweep;
    logic [2:0] prev;
    logic [2:0] v;
    prev = 3'b111;
    tick(4);
    for (int n = 0; n < 8; n++) begin
      v      = 3'(n);
      sw_raw = v;
      tick(5);
      checks++;
      if (sw_clean !== prev) begin
        errors++;
        $display("FAIL sweep_lag[%0d]: got clean=%b want %b", n, sw_clean, prev);
      end
      tick(1);
      checks++;
      if (sw_clean !== v || sw_changed !== (prev ^ v)) begin
        errors++;
        $display("FAIL sweep_step[%0d]: got clean=%b chg=%b want %b %b",
                 n, sw_clean, sw_changed, v, prev ^ v);
      end
      checks++;
      if ($countones(sw_clean) !== pop3(v)) begin
        errors++;
        $display("FAIL sweep_ledr[%0d]: got %0d want %0d", n, $countones(sw_clean), pop3(v));
      end
      tick(4);
      prev = v;
    end
    checks++;
    if (sw_valid !== 1'b1) begin
      errors++;
      $display("FAIL sweep_valid: got %b want 1", sw_valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    sw_raw = '0;
    test_reset();
    test_change();
    test_bounce();
    test_reset_mid_check();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
